// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle shared by the pipeline writeback stage, the MDU and the arbiter.
// master = request sources / port consumer side, slave = the arbiter.
interface rf_write_arbiter_if;
  logic        wb_v;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_v;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_r;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output wb_v, wb_addr, wb_data, md_v, md_addr, md_data,
    input  wb_stall, md_r, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_v, wb_addr, wb_data, md_v, md_addr, md_data,
    output wb_stall, md_r, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and the MDU.
// Optional bounded-wait MDU starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_write_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, MD = 2'd2} state_t;

  state_t      state_r;
  logic        grant_wb_s;
  logic        grant_md_s;
  logic        force_md_s;
  logic [4:0]  gnt_addr_s;
  logic [31:0] gnt_data_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait_cnt_r;

  // Force an MDU grant once it has been refused MAX_WAIT consecutive cycles.
  always_comb begin
    force_md_s = (wait_cnt_r == MAX_WAIT_C);
  end

  // Saturating count of consecutive refused MDU cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (bus.md_v && !grant_md_s) begin
      if (wait_cnt_r < MAX_WAIT_C) begin
        wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= MAX_WAIT_C;
      end
    end else begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end
  end
`else
  // Fixed priority: writeback always wins a tie.
  always_comb begin
    force_md_s = 1'b0;
  end
`endif

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    grant_wb_s = 1'b0;
    grant_md_s = 1'b0;
    if (!rst_n) begin
      grant_wb_s = 1'b0;
      grant_md_s = 1'b0;
    end else if (bus.wb_v && !(bus.md_v && force_md_s)) begin
      grant_wb_s = 1'b1;
    end else if (bus.md_v) begin
      grant_md_s = 1'b1;
    end else begin
      grant_wb_s = 1'b0;
      grant_md_s = 1'b0;
    end
  end

  // Select the granted source's write address and data.
  always_comb begin
    gnt_addr_s = bus.wb_addr;
    gnt_data_s = bus.wb_data;
    if (grant_md_s) begin
      gnt_addr_s = bus.md_addr;
      gnt_data_s = bus.md_data;
    end else begin
      gnt_addr_s = bus.wb_addr;
      gnt_data_s = bus.wb_data;
    end
  end

  // Same-cycle handshake back to the sources.
  always_comb begin
    bus.md_r = grant_md_s;
`ifdef ARB_STARVE_GUARD_EN
    bus.wb_stall = bus.wb_v & grant_md_s;
`else
    bus.wb_stall = 1'b0;
`endif
  end

  // Registered write port and last-grant state; x0 writes are consumed but not enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= 5'd0;
      bus.rf_data <= 32'd0;
      state_r     <= IDLE;
    end else begin
      bus.rf_we <= (grant_wb_s | grant_md_s) & (gnt_addr_s != 5'd0);
      if (grant_wb_s | grant_md_s) begin
        bus.rf_addr <= gnt_addr_s;
        bus.rf_data <= gnt_data_s;
      end else begin
        bus.rf_addr <= bus.rf_addr;
        bus.rf_data <= bus.rf_data;
      end
      case ({grant_md_s, grant_wb_s})
        2'b01:   state_r <= WB;
        2'b10:   state_r <= MD;
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two sources: the pipeline writeback stage and the multi-cycle mul/div unit (MDU).
- Pipeline has default priority. A bounded-wait starvation guard forces an MDU grant, stalling writeback for one cycle.
- Outputs drive the register-file write port directly, registered, with one-cycle latency.

Parameters:
- MAX_WAIT, 4, consecutive cycles an MDU request may be refused before it is force-granted (range 1..2^WAIT_W-1).
- WAIT_W, 3, width of the MDU wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wb_v  in  1  pipeline writeback result valid
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline result
- wb_stall  out  1  stall to pipeline writeback; result not consumed this cycle
- md_v  in  1  MDU result valid; held stable until accepted
- md_addr  in  5  MDU destination register
- md_data  in  32  MDU result
- md_r  out  1  MDU result accepted this cycle (md_v & md_r = transfer)
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data

Behaviour:
- Reset (rst_n low at a clk edge):
  - rf_we=0, rf_addr=0, rf_data=0, wait_cnt=0, state=IDLE.
  - wb_stall=0 and md_r=0 while rst_n is low.
  - Reset mid-transfer discards any pending write; no rf_we in the cycle after the reset edge.
- Grant decision is combinational from wb_v, md_v and wait_cnt:
  - Neither valid: no grant.
  - Only wb_v: grant WB.
  - Only md_v: grant MD.
  - Both valid: grant WB, unless wait_cnt == MAX_WAIT, then grant MD.
- Handshake outputs:
  - md_r = (grant == MD).
  - wb_stall = wb_v & (grant == MD).
  - wb_stall is never asserted when wb_v=0.
- Write port:
  - On each clk edge with a grant, rf_addr/rf_data <= granted source's addr/data.
  - rf_we <= 1 iff the granted addr != 0.
  - Writes to x0 are consumed (handshake completes) but never enabled.
  - No grant: rf_we <= 0; rf_addr/rf_data hold their previous values.
  - Latency: transfer in cycle N -> rf_we high in cycle N+1, for exactly one cycle per transfer.
- Wait counter:
  - md_v & !md_r: wait_cnt <= min(wait_cnt+1, MAX_WAIT).
  - md_v & md_r, or !md_v: wait_cnt <= 0.
- State register (last grant, for debug/observability): IDLE, WB, MD.
  - Any state -> WB on a WB grant, -> MD on an MD grant, -> IDLE on no grant.
  - Outputs do not otherwise depend on state.
- Simultaneous requests to the same rd: WB is written first, MD in a later cycle. Ordering correctness is the issue logic's responsibility; the arbiter neither merges nor drops writes.
- Back-to-back:
  - Both sources may transfer on consecutive cycles with no bubble.
  - Sustained wb_v=1 with md_v=1 yields exactly one MD grant per MAX_WAIT+1 cycles.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined: the wait counter and force-grant rule operate as above.
- Not defined:
  - Fixed priority; WB always wins when both are valid, and the MDU is granted only when wb_v=0.
  - wait_cnt is not implemented.
  - wb_stall is tied to 0.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release with all valids 0 -> rf_we=0, md_r=0, wb_stall=0, state=IDLE for 5 cycles.
- Single WB write: wb_v=1, wb_addr=5, wb_data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; following cycle rf_we=0.
- x0 suppression: md_v=1, md_addr=0, md_data=0x1234 with wb_v=0 -> md_r=1 same cycle; next cycle rf_we=0; wait_cnt=0.
- Contention, guard on: wb_v=1 continuously (addr 1..N), md_v=1 (addr 7, data 0x77), MAX_WAIT=4 -> md_r=0 for 4 cycles, then md_r=1 and wb_stall=1 in the 5th; next cycle rf_addr=7, rf_data=0x77; the stalled WB write appears the cycle after, with no WB result lost.
- Contention, guard off (macro undefined): same stimulus for 20 cycles -> md_r=0 throughout; then drop wb_v -> md_r=1 that cycle; rf_addr=7 the next cycle.
- Reset mid-operation: grant MD in cycle N with rst_n=0 at the same edge -> rf_we=0 in cycle N+1, wait_cnt=0; md_v still high after release -> accepted on the first cycle with wb_v=0.
